// File: rtl/onn_pkg.sv
// Shared types and constants for the oscillatory neural network sequencer.
// The FSM state enum lives here so every block decodes states the same way.
package onn_pkg;

    localparam int PHASE_W = 4;
    localparam int N_NEURONS_DEF = 15;
    localparam logic [PHASE_W-1:0] RESET_PHASE = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_DROP,
        S_SETTLE,
        S_CHECK,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_e;

endpackage

// File: rtl/onn_seq_ctrl_if.sv
// Control/status bundle between the sequencer and its host / phase array.
// The master side drives start, abort and the change flags.
interface onn_seq_ctrl_if
    import onn_pkg::*;
#(
    parameter int N = N_NEURONS_DEF
);
    logic         start;
    logic         abort;
    logic [N-1:0] state_changed;
    logic         re_pulse;
    logic         drop_pulse;
    logic         check_pulse;
    logic         busy;
    logic         done;
    logic         converged;
    logic         timed_out;
    logic [7:0]   iter_count;

    modport master (
        output start, abort, state_changed,
        input  re_pulse, drop_pulse, check_pulse,
        input  busy, done, converged, timed_out, iter_count
    );

    modport slave (
        input  start, abort, state_changed,
        output re_pulse, drop_pulse, check_pulse,
        output busy, done, converged, timed_out, iter_count
    );
endinterface

// File: rtl/onn_settle_timer.sv
// Loadable 8-bit down-counter; expired flags the last cycle of a settle window.
// A load of K yields exactly K cycles before expired is seen.
module onn_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       expired
);
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign expired = (cnt_q == 8'd1);
endmodule

// File: rtl/onn_seq_ctrl.sv
// ONN run sequencer: reset/drop/check triggers and stability detection.
// Define ONN_SEQ_TIMEOUT_EN to end runs after MAX_ITER check pulses.
module onn_seq_ctrl
    import onn_pkg::*;
#(
    parameter int N_NEURONS     = N_NEURONS_DEF,
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_CHECKS = 2,
    parameter int MAX_ITER      = 64
) (
    input logic           clk,
    input logic           rst_n,
    onn_seq_ctrl_if.slave bus
);
    state_e     state_q, state_d;
    logic [3:0] stable_q, stable_d, stable_inc;
    logic [7:0] iter_q, iter_d;
    logic       conv_q, conv_d;
    logic       to_q, to_d;
    logic       re_q, drop_q, chk_q, busy_q, done_q;
    logic       tmr_load, tmr_exp, any_chg;
    logic       unused_cfg;

    assign any_chg    = |bus.state_changed;
    assign stable_inc = stable_q + 4'd1;
    assign unused_cfg = ^{32'(MAX_ITER), 32'(N_NEURONS)};

    onn_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (8'(SETTLE_CYCLES)),
        .dec      (state_q == S_SETTLE),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        iter_d   = iter_q;
        conv_d   = conv_q;
        to_d     = to_q;
        tmr_load = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
            conv_d  = 1'b0;
            to_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d  = S_RESET;
                        iter_d   = '0;
                        stable_d = '0;
                        conv_d   = 1'b0;
                        to_d     = 1'b0;
                    end
                end
                S_RESET: state_d = S_DROP;
                S_DROP: begin
                    state_d  = S_SETTLE;
                    tmr_load = 1'b1;
                end
                S_SETTLE: begin
                    if (tmr_exp) begin
                        state_d = S_CHECK;
                        if (iter_q != 8'hFF) iter_d = iter_q + 8'd1;
                    end
                end
                S_CHECK: state_d = S_WAIT;
                S_WAIT:  state_d = S_EVAL;
                S_EVAL: begin
                    stable_d = any_chg ? 4'd0 : stable_inc;
                    // Convergence wins over timeout on the same evaluation.
                    if (!any_chg && stable_inc == 4'(STABLE_CHECKS)) begin
                        state_d = S_DONE;
                        conv_d  = 1'b1;
                    end
`ifdef ONN_SEQ_TIMEOUT_EN
                    else if (iter_q == 8'(MAX_ITER)) begin
                        state_d = S_DONE;
                        to_d    = 1'b1;
                    end
`endif
                    else begin
                        state_d  = S_SETTLE;
                        tmr_load = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are clean flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stable_q <= '0;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            to_q     <= 1'b0;
            re_q     <= 1'b0;
            drop_q   <= 1'b0;
            chk_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            iter_q   <= iter_d;
            conv_q   <= conv_d;
            to_q     <= to_d;
            re_q     <= (state_d == S_RESET);
            drop_q   <= (state_d == S_DROP);
            chk_q    <= (state_d == S_CHECK);
            busy_q   <= !(state_d == S_IDLE || state_d == S_DONE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.re_pulse    = re_q;
    assign bus.drop_pulse  = drop_q;
    assign bus.check_pulse = chk_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.converged   = conv_q;
    assign bus.iter_count  = iter_q;
`ifdef ONN_SEQ_TIMEOUT_EN
    assign bus.timed_out   = to_q;
`else
    assign bus.timed_out   = 1'b0;
`endif
endmodule

// File: tb/tb_onn_seq_ctrl.sv
// Bench for onn_seq_ctrl: scoreboard of run results plus a trigger event log.
// Timeout scenario depends on ONN_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_onn_seq_ctrl;
    localparam int S  = 16;
    localparam int SC = 2;
    localparam int MI = 4;

    typedef struct packed {
        logic       conv;
        logic       to;
        logic [7:0] iter;
    } res_t;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   n_chk = 0;
    int   multi_hot = 0;
    int   sc_mode = 0;
    res_t exp_q[$];
    ev_t  ev_q[$];

    onn_seq_ctrl_if #(.N(15)) bus ();

    onn_seq_ctrl #(
        .N_NEURONS     (15),
        .SETTLE_CYCLES (S),
        .STABLE_CHECKS (SC),
        .MAX_ITER      (MI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Trigger monitor and phase-array stand-in.
    always @(negedge clk) begin
        if (bus.re_pulse) begin
            ev_q.push_back('{1, cyc});
            n_chk = 0;
        end
        if (bus.drop_pulse) ev_q.push_back('{2, cyc});
        if (bus.check_pulse) begin
            ev_q.push_back('{3, cyc});
            n_chk++;
        end
        if (32'(bus.re_pulse) + 32'(bus.drop_pulse) + 32'(bus.check_pulse) > 1)
            multi_hot++;
        case (sc_mode)
            1: bus.state_changed = 15'h0001;
            2: bus.state_changed = (n_chk < 4) ? 15'($urandom_range(1, 32767)) : 15'h0;
            default: bus.state_changed = 15'h0;
        endcase
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        sc_mode = 0;
        repeat (3) tick();
        total++;
        if ({bus.re_pulse, bus.drop_pulse, bus.check_pulse, bus.busy,
             bus.done, bus.converged, bus.timed_out} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000",
                     {bus.re_pulse, bus.drop_pulse, bus.check_pulse, bus.busy,
                      bus.done, bus.converged, bus.timed_out});
        else passed++;
        total++;
        if (bus.iter_count !== 8'd0)
            $display("FAIL reset_iter: got %0d want 0", bus.iter_count);
        else passed++;
        rst_n = 1'b1;
        repeat (2) tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_idle: busy %b done %b want 0 0", bus.busy, bus.done);
        else passed++;
    endtask

    task automatic test_converge_static();
        bit   ok;
        res_t e, g;
        sc_mode = 0;
        ev_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 8'd2});
        pulse_start();
        wait_done(200, ok);
        total++;
        if (!ok) $display("FAIL static_done: no done within 200 cycles");
        else passed++;
        e = exp_q.pop_front();
        g = {bus.converged, bus.timed_out, bus.iter_count};
        total++;
        if (g !== e) $display("FAIL static_result: got %h want %h", g, e);
        else passed++;
        total++;
        if (ev_q.size() != 4 || ev_q[0].code != 1 || ev_q[1].code != 2 ||
            ev_q[2].code != 3 || ev_q[3].code != 3)
            $display("FAIL static_order: got %0d events want re,drop,check,check", ev_q.size());
        else passed++;
        total++;
        if (ev_q[1].cyc - ev_q[0].cyc != 1 || ev_q[2].cyc - ev_q[1].cyc != S + 1 ||
            ev_q[3].cyc - ev_q[2].cyc != S + 3)
            $display("FAIL static_spacing: got %0d/%0d/%0d want 1/%0d/%0d",
                     ev_q[1].cyc - ev_q[0].cyc, ev_q[2].cyc - ev_q[1].cyc,
                     ev_q[3].cyc - ev_q[2].cyc, S + 1, S + 3);
        else passed++;
    endtask

    task automatic test_change_then_stable();
        bit   ok;
        int   nck, bad;
        int   last;
        res_t e, g;
        sc_mode = 2;
        ev_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 8'd5});
        pulse_start();
        wait_done(400, ok);
        total++;
        if (!ok) $display("FAIL change_done: no done within 400 cycles");
        else passed++;
        e = exp_q.pop_front();
        g = {bus.converged, bus.timed_out, bus.iter_count};
        total++;
        if (g !== e) $display("FAIL change_result: got %h want %h", g, e);
        else passed++;
        nck = 0;
        bad = 0;
        last = -1;
        foreach (ev_q[i]) begin
            if (ev_q[i].code == 3) begin
                if (last >= 0 && ev_q[i].cyc - last != S + 3) bad++;
                last = ev_q[i].cyc;
                nck++;
            end
        end
        total++;
        if (nck != 5 || bad != 0)
            $display("FAIL change_checks: got %0d checks %0d bad gaps want 5 checks 0 bad", nck, bad);
        else passed++;
        sc_mode = 0;
    endtask

    task automatic test_timeout();
        bit   ok;
        res_t e, g;
        sc_mode = 1;
`ifdef ONN_SEQ_TIMEOUT_EN
        exp_q.push_back('{1'b0, 1'b1, 8'(MI)});
        pulse_start();
        wait_done(300, ok);
        total++;
        if (!ok) $display("FAIL timeout_done: no done within 300 cycles");
        else passed++;
        e = exp_q.pop_front();
        g = {bus.converged, bus.timed_out, bus.iter_count};
        total++;
        if (g !== e) $display("FAIL timeout_result: got %h want %h", g, e);
        else passed++;
`else
        e = '{1'b0, 1'b0, 8'd6};
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (n_chk >= 6) begin
                ok = 1'b1;
                break;
            end
        end
        g = {bus.converged, bus.done, bus.iter_count};
        total++;
        if (!ok || g !== e || bus.busy !== 1'b1)
            $display("FAIL no_timeout_run: got %h busy %b want %h busy 1", g, bus.busy, e);
        else passed++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.timed_out !== 1'b0)
            $display("FAIL no_timeout_abort: busy %b timed_out %b want 0 0", bus.busy, bus.timed_out);
        else passed++;
`endif
        sc_mode = 0;
    endtask

    task automatic test_abort();
        bit ok;
        int n;
        sc_mode = 1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_chk == 2) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
        total++;
        if (!ok || bus.busy !== 1'b1)
            $display("FAIL abort_setup: reached %b busy %b want 1 1", ok, bus.busy);
        else passed++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.converged, bus.iter_count} !== {3'b000, 8'd2})
            $display("FAIL abort_idle: busy %b done %b conv %b iter %0d want 0 0 0 2",
                     bus.busy, bus.done, bus.converged, bus.iter_count);
        else passed++;
        n = ev_q.size();
        repeat (40) tick();
        total++;
        if (ev_q.size() != n || bus.iter_count !== 8'd2 || bus.busy !== 1'b0)
            $display("FAIL abort_quiet: events %0d->%0d iter %0d busy %b want no new, 2, 0",
                     n, ev_q.size(), bus.iter_count, bus.busy);
        else passed++;
        sc_mode = 0;
    endtask

    task automatic test_async_reset();
        bit   ok;
        res_t e, g;
        sc_mode = 0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.check_pulse) begin
                ok = 1'b1;
                break;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (!ok || {bus.re_pulse, bus.drop_pulse, bus.check_pulse, bus.busy, bus.done,
                    bus.converged, bus.timed_out, bus.iter_count} !== 15'b0)
            $display("FAIL async_reset: in_check %b outs %b iter %0d want 1 0000000 0",
                     ok, {bus.re_pulse, bus.drop_pulse, bus.check_pulse, bus.busy,
                          bus.done, bus.converged, bus.timed_out}, bus.iter_count);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL async_idle: busy %b done %b want 0 0", bus.busy, bus.done);
        else passed++;
        ev_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 8'd2});
        pulse_start();
        wait_done(200, ok);
        e = exp_q.pop_front();
        g = {bus.converged, bus.timed_out, bus.iter_count};
        total++;
        if (!ok || g !== e) $display("FAIL async_replay: done %b got %h want %h", ok, g, e);
        else passed++;
        total++;
        if (ev_q.size() != 4 || ev_q[0].code != 1 || ev_q[1].code != 2 || ev_q[2].code != 3)
            $display("FAIL async_replay_order: got %0d events want 4 in order", ev_q.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit   ok;
        int   nre;
        res_t e, g;
        sc_mode = 0;
        ev_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 8'd2});
        exp_q.push_back('{1'b1, 1'b0, 8'd2});
        bus.start = 1'b1;
        wait_done(200, ok);
        e = exp_q.pop_front();
        g = {bus.converged, bus.timed_out, bus.iter_count};
        total++;
        if (!ok || g !== e) $display("FAIL b2b_first: done %b got %h want %h", ok, g, e);
        else passed++;
        nre = 0;
        foreach (ev_q[i]) if (ev_q[i].code == 1) nre++;
        total++;
        if (nre != 1) $display("FAIL b2b_ignored: got %0d resets want 1", nre);
        else passed++;
        tick();
        total++;
        if ({bus.re_pulse, bus.done, bus.busy, bus.iter_count} !== {3'b101, 8'd0})
            $display("FAIL b2b_restart: re %b done %b busy %b iter %0d want 1 0 1 0",
                     bus.re_pulse, bus.done, bus.busy, bus.iter_count);
        else passed++;
        bus.start = 1'b0;
        wait_done(200, ok);
        e = exp_q.pop_front();
        g = {bus.converged, bus.timed_out, bus.iter_count};
        total++;
        if (!ok || g !== e) $display("FAIL b2b_second: done %b got %h want %h", ok, g, e);
        else passed++;
        total++;
        if (multi_hot != 0) $display("FAIL trigger_overlap: got %0d cycles want 0", multi_hot);
        else passed++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_converge_static();
        test_change_then_stable();
        test_timeout();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
